// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory-controller line port between the I-cache fill path and
// the D-cache fill/writeback path.
//
// Round-robin arbitration between the two requesters. The winner's address, direction and write
// data are captured at grant and held on the memory port for the whole transaction. A watchdog
// aborts a transaction that memory never answers and reports an error to the owner.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ic_req_i, ic_addr_i    I-side request (held until ic_ready_o/ic_error_o)
//   ic_rdata_o             I-side fill data, valid with ic_ready_o
//   ic_ready_o, ic_error_o I-side one-cycle completion / error pulses
//   dc_req_i, dc_wr_i      D-side request, write (writeback) when dc_wr_i=1
//   dc_addr_i, dc_wdata_i  D-side line address / writeback data
//   dc_rdata_o             D-side fill data, valid with dc_ready_o
//   dc_ready_o, dc_error_o D-side one-cycle completion / error pulses
//   mem_req_o ... mem_wdata_o  memory request side (registered fields)
//   mem_rdata_i, mem_ready_i, mem_error_i  memory response side
//   arb_state_o            current FSM state (0 idle, 1 busy, 2 resp)
//   timeout_cnt_o          saturating count of watchdog aborts
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W  = 36,
  parameter int unsigned LINE_W  = 288,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [LINE_W-1:0] ic_rdata_o,
  output logic              ic_ready_o,
  output logic              ic_error_o,
  input  logic              dc_req_i,
  input  logic              dc_wr_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              dc_ready_o,
  output logic              dc_error_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  input  logic              mem_error_i,
  output logic [1:0]        arb_state_o,
  output logic [15:0]       timeout_cnt_o
);

  localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 0: I-side, 1: D-side
  logic                rr_q, rr_d;        // last grantee, same encoding as owner
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic [15:0]         tcnt_q, tcnt_d;
  logic                grant_dc;
  logic [LINE_W-1:0]   resp_data;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    wr_d       = wr_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    wd_d       = wd_q;
    tcnt_d     = tcnt_q;
    // On a tie the side that did not win last time gets the grant.
    grant_dc   = dc_req_i && (!ic_req_i || !rr_q);
    resp_data  = '0;

    unique case (state_q)
      StIdle: begin
        if (ic_req_i || dc_req_i) begin
          owner_d = grant_dc;
          rr_d    = grant_dc;
          addr_d  = grant_dc ? dc_addr_i : ic_addr_i;
          wr_d    = grant_dc && dc_wr_i;
          wdata_d = (grant_dc && dc_wr_i) ? dc_wdata_i : '0;
          wd_d    = '0;
          err_d   = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (mem_error_i || mem_ready_i || (wd_q == WdW'(TIMEOUT - 1))) begin
          // Error (memory or watchdog) takes precedence over ready; writes return zero data.
          err_d = mem_error_i || !mem_ready_i;
          if (!mem_error_i && mem_ready_i && !wr_q) begin
            resp_data = mem_rdata_i;
          end
          if (owner_q) begin
            dc_rdata_d = resp_data;
          end else begin
            ic_rdata_d = resp_data;
          end
          if (!mem_error_i && !mem_ready_i && (tcnt_q != 16'hFFFF)) begin
            tcnt_d = tcnt_q + 16'd1;
          end
          state_d = StResp;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      wd_q       <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      wd_q       <= wd_d;
      tcnt_q     <= tcnt_d;
    end
  end

  always_comb begin
    mem_req_o     = (state_q == StBusy);
    mem_wr_o      = wr_q;
    mem_addr_o    = addr_q;
    mem_wdata_o   = wdata_q;
    ic_ready_o    = (state_q == StResp) && !owner_q && !err_q;
    ic_error_o    = (state_q == StResp) && !owner_q && err_q;
    dc_ready_o    = (state_q == StResp) && owner_q && !err_q;
    dc_error_o    = (state_q == StResp) && owner_q && err_q;
    ic_rdata_o    = ic_rdata_q;
    dc_rdata_o    = dc_rdata_q;
    arb_state_o   = state_q;
    timeout_cnt_o = tcnt_q;
  end

endmodule
